// File: rtl/regfile_scoreboard.sv
// NREAD-port register file with two write ports and a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-through forwarding on the read ports.
module regfile_scoreboard #(
    parameter int W     = 32,
    parameter int DEPTH = 32,
    parameter int NREAD = 2,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                WE0,
    input  logic [AW-1:0]       WAddr0,
    input  logic [W-1:0]        WData0,
    input  logic                WE1,
    input  logic [AW-1:0]       WAddr1,
    input  logic [W-1:0]        WData1,
    input  logic                Reserve,
    input  logic [AW-1:0]       ReserveAddr,
    output logic                ReserveGrant,
    input  logic [NREAD*AW-1:0] RdAddr,
    output logic [NREAD*W-1:0]  RdData,
    output logic [NREAD-1:0]    RdBusy,
    output logic                AnyBusy,
    output logic                Conflict
);
    // Slots past DEPTH (non power-of-two depths) read as zero and never go busy.
    localparam int NSLOT = 1 << AW;

    logic [NSLOT*W-1:0] regs_flat;
    logic [NSLOT-1:0]   busy;
    logic               conflict_reg;
    logic               conflict_next;

    assign ReserveGrant = Reserve & ((ReserveAddr == '0) | ~busy[ReserveAddr]
                                     | (WE1 & (WAddr1 == ReserveAddr)));
    assign AnyBusy  = |busy;
    assign Conflict = conflict_reg;

    always_comb begin
        conflict_next = 1'b0;
        if (WE0 && (WAddr0 != '0)) begin
            if (WE1 && (WAddr1 == WAddr0)) conflict_next = 1'b1;
            if (busy[WAddr0])              conflict_next = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) conflict_reg <= 1'b0;
        else        conflict_reg <= conflict_next;
    end

    generate
        for (genvar gi = 0; gi < NSLOT; gi++) begin : g_reg
            if (gi == 0 || gi >= DEPTH) begin : g_zero
                assign regs_flat[gi*W +: W] = '0;
                assign busy[gi]             = 1'b0;
            end else begin : g_live
                logic [W-1:0] data_reg;
                logic         busy_reg;
                logic         busy_next;
                logic         we0_hit;
                logic         we1_hit;

                assign we0_hit = WE0 && (WAddr0 == AW'(gi));
                assign we1_hit = WE1 && (WAddr1 == AW'(gi));

                // A fresh reservation outranks a completion landing in the same cycle.
                always_comb begin
                    busy_next = busy_reg;
                    if (ReserveGrant && (ReserveAddr == AW'(gi))) busy_next = 1'b1;
                    else if (we1_hit)                             busy_next = 1'b0;
                end

                always_ff @(posedge CLK or negedge RST_N) begin
                    if (!RST_N) begin
                        data_reg <= '0;
                        busy_reg <= 1'b0;
                    end else begin
                        if (we0_hit)      data_reg <= WData0;
                        else if (we1_hit) data_reg <= WData1;
                        busy_reg <= busy_next;
                    end
                end

                assign regs_flat[gi*W +: W] = data_reg;
                assign busy[gi]             = busy_reg;
            end
        end

        for (genvar gi = 0; gi < NREAD; gi++) begin : g_rd
            logic [AW-1:0] addr;
            logic [W-1:0]  arr_data;

            assign addr     = RdAddr[gi*AW +: AW];
            assign arr_data = regs_flat[int'(addr)*W +: W];
`ifdef REGFILE_BYPASS_EN
            logic hit0;
            logic hit1;

            assign hit0 = WE0 && (WAddr0 == addr) && (addr != '0);
            assign hit1 = WE1 && (WAddr1 == addr) && (addr != '0);
            assign RdData[gi*W +: W] = hit0 ? WData0 : (hit1 ? WData1 : arr_data);
            assign RdBusy[gi]        = busy[addr] & ~hit1;
`else
            assign RdData[gi*W +: W] = arr_data;
            assign RdBusy[gi]        = busy[addr];
`endif
        end
    endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: driver pushes predicted responses,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_scoreboard;
    localparam int W     = 32;
    localparam int DEPTH = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic                CLK = 1'b0;
    logic                RST_N = 1'b0;
    logic                WE0 = 1'b0, WE1 = 1'b0, Reserve = 1'b0;
    logic [AW-1:0]       WAddr0 = '0, WAddr1 = '0, ReserveAddr = '0;
    logic [W-1:0]        WData0 = '0, WData1 = '0;
    logic                ReserveGrant, AnyBusy, Conflict;
    logic [NREAD*AW-1:0] RdAddr = '0;
    logic [NREAD*W-1:0]  RdData;
    logic [NREAD-1:0]    RdBusy;

    regfile_scoreboard #(.W(W), .DEPTH(DEPTH), .NREAD(NREAD)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .WE0(WE0), .WAddr0(WAddr0), .WData0(WData0),
        .WE1(WE1), .WAddr1(WAddr1), .WData1(WData1),
        .Reserve(Reserve), .ReserveAddr(ReserveAddr), .ReserveGrant(ReserveGrant),
        .RdAddr(RdAddr), .RdData(RdData), .RdBusy(RdBusy),
        .AnyBusy(AnyBusy), .Conflict(Conflict)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [NREAD*W-1:0] rd;
        logic [NREAD-1:0]   rdbusy;
        logic               grant;
        logic               anybusy;
        logic               conflict;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         mon_e;
    logic [W-1:0] m_rf [DEPTH];
    bit           m_busy [DEPTH];
    bit           m_conflict;
    int           n_cmp = 0;
    int           n_err = 0;
    int           n_txn = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_rf[i]   = '0;
            m_busy[i] = 1'b0;
        end
        m_conflict = 1'b0;
    endtask

    // Expected outputs for the current inputs and the architectural state.
    function automatic exp_t predict();
        exp_t         e;
        bit           any;
        logic [AW-1:0] a;
        logic [W-1:0] d;
        bit           b;
        any = 1'b0;
        for (int i = 0; i < DEPTH; i++) any = any | m_busy[i];
        e.anybusy  = any;
        e.conflict = m_conflict;
        e.grant    = Reserve && (ReserveAddr == 0 || !m_busy[ReserveAddr]
                                 || (WE1 && WAddr1 == ReserveAddr));
        for (int k = 0; k < NREAD; k++) begin
            a = RdAddr[k*AW +: AW];
            d = m_rf[a];
            b = m_busy[a];
`ifdef REGFILE_BYPASS_EN
            if (a != 0 && WE0 && WAddr0 == a)      d = WData0;
            else if (a != 0 && WE1 && WAddr1 == a) d = WData1;
            if (WE1 && WAddr1 == a) b = 1'b0;
`endif
            e.rd[k*W +: W] = d;
            e.rdbusy[k]    = b;
        end
        return e;
    endfunction

    task automatic model_step(input bit grant);
        m_conflict = WE0 && WAddr0 != 0 && ((WE1 && WAddr1 == WAddr0) || m_busy[WAddr0]);
        if (WE1 && WAddr1 != 0) begin
            m_rf[WAddr1]   = WData1;
            m_busy[WAddr1] = 1'b0;
        end
        if (WE0 && WAddr0 != 0) m_rf[WAddr0] = WData0;
        if (grant && ReserveAddr != 0) m_busy[ReserveAddr] = 1'b1;
    endtask

    // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
    task automatic drive(input bit we0, input logic [AW-1:0] a0, input logic [W-1:0] d0,
                         input bit we1, input logic [AW-1:0] a1, input logic [W-1:0] d1,
                         input bit res, input logic [AW-1:0] ra,
                         input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        exp_t e;
        WE0 = we0; WAddr0 = a0; WData0 = d0;
        WE1 = we1; WAddr1 = a1; WData1 = d1;
        Reserve = res; ReserveAddr = ra;
        RdAddr = {r1, r0};
        e = predict();
        exp_q.push_back(e);
        @(posedge CLK);
        model_step(e.grant);
        #1;
    endtask

    task automatic idle_read(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
    endtask

    always @(negedge CLK) begin
        if (RST_N && exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_txn++;
            check("rd0",      64'(RdData[0 +: W]), 64'(mon_e.rd[0 +: W]));
            check("rd1",      64'(RdData[W +: W]), 64'(mon_e.rd[W +: W]));
            check("rdbusy",   64'(RdBusy),         64'(mon_e.rdbusy));
            check("grant",    64'(ReserveGrant),   64'(mon_e.grant));
            check("anybusy",  64'(AnyBusy),        64'(mon_e.anybusy));
            check("conflict", 64'(Conflict),       64'(mon_e.conflict));
            $display("txn %0d: rd0=%h rd1=%h rdbusy=%b grant=%b any=%b conf=%b",
                     n_txn, RdData[0 +: W], RdData[W +: W], RdBusy, ReserveGrant,
                     AnyBusy, Conflict);
        end
    end

    initial begin
        #200000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        model_reset();
        #12;
        check("reset_rd",       64'(RdData),  64'(0));
        check("reset_rdbusy",   64'(RdBusy),  64'(0));
        check("reset_anybusy",  64'(AnyBusy), 64'(0));
        check("reset_conflict", 64'(Conflict), 64'(0));
        RST_N = 1'b1;
        @(posedge CLK); #1;

        // Mid-cycle asynchronous reset with live data and a busy bit.
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 5, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 8, 5, 8);
        idle_read(5, 8);
        #1;
        check("pre_reset_r5",      64'(RdData[0 +: W]), 64'h0000_0000_DEAD_BEEF);
        check("pre_reset_anybusy", 64'(AnyBusy), 64'(1));
        RST_N = 1'b0;
        #1;
        check("async_reset_r5",       64'(RdData[0 +: W]), 64'(0));
        check("async_reset_rdbusy",   64'(RdBusy),  64'(0));
        check("async_reset_anybusy",  64'(AnyBusy), 64'(0));
        check("async_reset_conflict", 64'(Conflict), 64'(0));
        model_reset();
        #1;
        RST_N = 1'b1;
        @(posedge CLK); #1;

        // Register 0 ignores writes and reservations.
        drive(1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 0);
        idle_read(0, 0);
        // Reserve, refused re-reserve, completion.
        drive(0, 0, 0, 0, 0, 0, 1, 8, 8, 0);
        drive(0, 0, 0, 0, 0, 0, 1, 8, 8, 0);
        drive(0, 0, 0, 1, 8, 32'h12345678, 0, 0, 8, 0);
        idle_read(8, 0);
        // Same-address dual write.
        drive(1, 3, 32'hAAAA0000, 1, 3, 32'h5555FFFF, 0, 0, 3, 0);
        idle_read(3, 0);
        idle_read(3, 0);
        // Reservation overriding a completion on r9.
        drive(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
        drive(0, 0, 0, 1, 9, 32'h9999_0009, 1, 9, 9, 0);
        idle_read(9, 0);
        drive(0, 0, 0, 1, 9, 32'h0000_9999, 0, 0, 9, 0);
        // WAW onto a busy register.
        drive(0, 0, 0, 0, 0, 0, 1, 4, 4, 0);
        drive(1, 4, 32'h0404_0404, 0, 0, 0, 0, 0, 4, 0);
        drive(0, 0, 0, 1, 4, 32'h4444_4444, 0, 0, 4, 0);
        // Write visibility timing.
        drive(1, 7, 32'hCAFEF00D, 0, 0, 0, 0, 0, 7, 7);
        idle_read(7, 0);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 2) == 0, 5'($urandom_range(0, 11)), $urandom(),
                  $urandom_range(0, 2) == 0, 5'($urandom_range(0, 11)), $urandom(),
                  $urandom_range(0, 1) == 0, 5'($urandom_range(0, 11)),
                  5'($urandom_range(0, 11)), 5'($urandom_range(0, 11)));
        end
        idle_read(0, 0);

        @(negedge CLK); #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the single-write, dual-read GPR file.
- Configurable width, depth and read-port count.
- Adds a second write port for long-latency units (MULT/DIV, loads) and a per-register busy scoreboard for RAW hazard detection.
- Sits in ID stage: read ports feed operand muxes; write port 0 from WB, write port 1 from long-latency completion; RdBusy drives hazard unit stall.

Parameters:
- W, 32, data width of each register.
- DEPTH, 32, number of registers; AW = $clog2(DEPTH) derived locally.
- NREAD, 2, number of independent read ports.

Ports:
- CLK  input  1  clock, rising edge.
- RST_N  input  1  asynchronous active-low reset.
- WE0  input  1  write enable, pipeline WB port.
- WAddr0  input  AW  write address, port 0.
- WData0  input  W  write data, port 0.
- WE1  input  1  write enable, long-latency completion port; clears busy.
- WAddr1  input  AW  write address, port 1.
- WData1  input  W  write data, port 1.
- Reserve  input  1  issue of long-latency op; requests busy set on ReserveAddr.
- ReserveAddr  input  AW  destination being reserved.
- ReserveGrant  output  1  combinational: reservation accepted this cycle.
- RdAddr  input  NREAD*AW  packed read addresses; port k at [k*AW +: AW].
- RdData  output  NREAD*W  packed read data; port k at [k*W +: W].
- RdBusy  output  NREAD  per-port hazard: source register has a pending result.
- AnyBusy  output  1  OR of all busy bits (registered state).
- Conflict  output  1  registered one-cycle error pulse.

Behaviour:
- Reset: RST_N low asynchronously clears all DEPTH registers to 0, all busy bits, and Conflict. AnyBusy=0; all RdData=0; RdBusy=0.
- Register 0: hardwired zero. Reads return 0. Writes are ignored. Never busy. Reserve of addr 0 gives ReserveGrant=1 with no state change.
- Writes: registered on rising CLK.
  - WE0 and WE1 to the same nonzero address in the same cycle: WE0 data wins.
- Reads: combinational from array (see BYPASS_EN).
- Scoreboard, per register r (r != 0), next busy[r]:
  - set if Reserve & ReserveGrant & ReserveAddr==r;
  - else clear if WE1 & WAddr1==r;
  - else hold.
  - Reserve and WE1 to the same r in the same cycle: busy ends set (new reservation overrides completion).
- ReserveGrant = Reserve & (ReserveAddr==0 | ~busy[ReserveAddr] | (WE1 & WAddr1==ReserveAddr)).
  - Reserve to a busy register without a same-cycle completion is refused: ReserveGrant=0, no state change. The issuer must stall and retry.
- WE0 does not affect busy bits.
- Conflict: asserted for exactly the cycle after either event, otherwise 0:
  - WE0 & WE1 to the same nonzero address;
  - WE0 to a nonzero address whose busy bit is set (WAW violation).
- AnyBusy = |busy, from registered state only.
- Latency: write visible on read one cycle after the write edge (zero cycles with BYPASS_EN). Busy set visible on RdBusy the cycle after grant.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined (write-through forwarding):
  - RdData for port k returns WData0 if WE0 & WAddr0==RdAddr_k != 0.
  - Else returns WData1 if WE1 & WAddr1==RdAddr_k != 0.
  - Else returns the array value.
  - RdBusy_k = busy[RdAddr_k] & ~(WE1 & WAddr1==RdAddr_k).
- Undefined:
  - RdData is the array value only.
  - RdBusy_k = busy[RdAddr_k]; the hazard unit stalls one extra cycle.

Test Plan:
- Reset: write 0xDEADBEEF to r5, then pulse RST_N low mid-cycle -> RdData(r5)=0 immediately, AnyBusy=0, Conflict=0.
- r0: WE0 to addr 0 with 0xFFFFFFFF; Reserve addr 0 -> RdData(r0)=0, ReserveGrant=1, AnyBusy stays 0.
- Scoreboard:
  - Reserve r8 -> next cycle RdBusy=1 for a port reading r8, AnyBusy=1.
  - Second Reserve r8 -> ReserveGrant=0.
  - WE1 r8 with 0x12345678 -> next cycle RdBusy=0, RdData=0x12345678.
- Collision: WE0 r3=0xAAAA0000 and WE1 r3=0x5555FFFF in the same cycle -> r3=0xAAAA0000, Conflict=1 for one cycle.
- Reserve and WE1 on r9 in the same cycle while r9 is busy -> ReserveGrant=1, busy[r9] stays 1, r9 holds WData1.
- Bypass:
  - With REGFILE_BYPASS_EN, WE0 r7=0xCAFEF00D and read r7 in the same cycle -> RdData=0xCAFEF00D.
  - Without the macro -> old r7 value that cycle, new value the next cycle.
